// File: rtl/clause_break_evaluator_if.sv
// Bus between the break evaluator, its requester, the Clause Table and the
// variable-assignment memory.
interface clause_break_evaluator_if #(
    parameter int CLAUSE_COUNT           = 20,
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int NSAT                   = 3
);
    localparam int LIT_W    = VARIABLE_ADDRESS_WIDTH + 1;
    localparam int CT_WIDTH = LIT_W * (NSAT - 1) * CLAUSE_COUNT;
    localparam int CNT_W    = $clog2(CLAUSE_COUNT + 1);

    // Handshake: start_i is accepted on a rising edge only while busy_o is low;
    // busy_o then stays high until the cycle after done_o, and done_o pulses for
    // exactly one cycle alongside the updated break_count_o.
    logic                              start_i;
    logic [VARIABLE_ADDRESS_WIDTH-1:0] var_i;
    logic                              busy_o;
    logic                              done_o;
    logic [CNT_W-1:0]                  break_count_o;
    logic [VARIABLE_ADDRESS_WIDTH-1:0] ct_rd_addr_o;
    logic [CT_WIDTH-1:0]               ct_clauses_i;
    logic [VARIABLE_ADDRESS_WIDTH-1:0] var_rd_addr_o;
    logic                              var_val_i;
    logic [2:0]                        state_dbg;

    modport slave (
        input  start_i, var_i, ct_clauses_i, var_val_i,
        output busy_o, done_o, break_count_o, ct_rd_addr_o, var_rd_addr_o, state_dbg
    );

    modport master (
        output start_i, var_i, ct_clauses_i, var_val_i,
        input  busy_o, done_o, break_count_o, ct_rd_addr_o, var_rd_addr_o, state_dbg
    );
endinterface

// File: rtl/clause_break_evaluator.sv
// Computes the break count of one candidate variable by serially scanning the
// clause list returned by the Clause Table against the current assignment.
module clause_break_evaluator #(
    parameter int CLAUSE_COUNT           = 20,
    parameter int VARIABLE_ADDRESS_WIDTH = 11,
    parameter int NSAT                   = 3
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    clause_break_evaluator_if.slave bus
);
    localparam int VAW      = VARIABLE_ADDRESS_WIDTH;
    localparam int LIT_W    = VAW + 1;
    localparam int SLOT_W   = LIT_W * (NSAT - 1);
    localparam int CT_WIDTH = SLOT_W * CLAUSE_COUNT;
    localparam int CNT_W    = $clog2(CLAUSE_COUNT + 1);
    localparam int L        = CLAUSE_COUNT * (NSAT - 1);
    localparam int IDX_W    = (L > 1) ? $clog2(L) : 1;
    localparam int K_W      = (NSAT > 2) ? $clog2(NSAT - 1) : 1;
    localparam int SLOT_IW  = (CLAUSE_COUNT > 1) ? $clog2(CLAUSE_COUNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_EVAL    = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CNT_W-1:0]     break_count_q;
    logic [VAW-1:0]       ct_rd_addr_q;
    logic [CT_WIDTH-1:0]  clauses_q;
    logic [IDX_W-1:0]     lit_idx_q;
    logic [K_W-1:0]       lit_k_q;
    logic [SLOT_IW-1:0]   lit_slot_q;
    // The pend_* registers describe the literal whose assignment bit arrives this cycle.
    logic                 pend_vld_q;
    logic [IDX_W-1:0]     pend_idx_q;
    logic [K_W-1:0]       pend_k_q;
    logic [SLOT_IW-1:0]   pend_slot_q;
    logic                 all_false_q;
    logic [CNT_W-1:0]     count_q;

    logic                 pend_neg;
    logic                 pend_slot_valid;
    logic                 lit_false;
    logic                 slot_false;
    logic                 hit;
    logic [CNT_W-1:0]     count_next;

    always_comb begin
        pend_neg        = clauses_q[pend_idx_q * LIT_W + (LIT_W - 1)];
        pend_slot_valid = |clauses_q[pend_slot_q * SLOT_W +: SLOT_W];
        lit_false       = ~(bus.var_val_i ^ pend_neg);
        slot_false      = lit_false & ((pend_k_q == '0) | all_false_q);
        hit             = pend_vld_q & (pend_k_q == K_W'(NSAT - 2)) & pend_slot_valid & slot_false;
        count_next      = count_q + CNT_W'(hit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            break_count_q <= '0;
            ct_rd_addr_q  <= '0;
            clauses_q     <= '0;
            lit_idx_q     <= '0;
            lit_k_q       <= '0;
            lit_slot_q    <= '0;
            pend_vld_q    <= 1'b0;
            pend_idx_q    <= '0;
            pend_k_q      <= '0;
            pend_slot_q   <= '0;
            all_false_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            if (pend_vld_q) begin
                all_false_q <= slot_false;
                count_q     <= count_next;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        ct_rd_addr_q <= bus.var_i;
                        busy_q       <= 1'b1;
                        state_q      <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    clauses_q  <= bus.ct_clauses_i;
                    count_q    <= '0;
                    lit_idx_q  <= '0;
                    lit_k_q    <= '0;
                    lit_slot_q <= '0;
                    state_q    <= S_EVAL;
                end
                S_EVAL: begin
                    pend_vld_q  <= 1'b1;
                    pend_idx_q  <= lit_idx_q;
                    pend_k_q    <= lit_k_q;
                    pend_slot_q <= lit_slot_q;
                    // lit_idx stays on the last literal so the read address holds through DRAIN.
                    if (lit_idx_q == IDX_W'(L - 1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        lit_idx_q <= lit_idx_q + 1'b1;
                        if (lit_k_q == K_W'(NSAT - 2)) begin
                            lit_k_q    <= '0;
                            lit_slot_q <= lit_slot_q + 1'b1;
                        end else begin
                            lit_k_q <= lit_k_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    done_q        <= 1'b1;
                    break_count_q <= count_next;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.break_count_o = break_count_q;
    assign bus.ct_rd_addr_o  = ct_rd_addr_q;
    assign bus.var_rd_addr_o = clauses_q[lit_idx_q * LIT_W +: VAW];
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_clause_break_evaluator.sv
// Directed bench for clause_break_evaluator with behavioural Clause Table and
// assignment memory models, one task per scenario.
module tb_clause_break_evaluator;
  localparam int CC    = 20;
  localparam int VAW   = 11;
  localparam int NS    = 3;
  localparam int LIT_W = VAW + 1;
  localparam int CTW   = LIT_W * (NS - 1) * CC;
  localparam int CNT_W = 5;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [CTW-1:0] tbl_word;
  logic [VAW-1:0] tbl_addr;
  logic           var_mem [0:2047];

  clause_break_evaluator_if bus ();

  clause_break_evaluator dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clause Table and assignment memory: synchronous reads, one cycle latency
  always @(posedge clk) begin
    bus.ct_clauses_i <= (bus.ct_rd_addr_o == tbl_addr) ? tbl_word : '0;
    bus.var_val_i    <= var_mem[bus.var_rd_addr_o];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [LIT_W-1:0] lit(input logic neg, input int addr);
    logic [LIT_W-1:0] l;
    l = {neg, VAW'(addr)};
    return l;
  endfunction

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) var_mem[i] = 1'b0;
    tbl_word = '0;
  endtask

  task automatic set_single();
    clear_mem();
    tbl_addr = 11'd9;
    tbl_word[0 +: LIT_W]     = lit(1'b0, 5);
    tbl_word[LIT_W +: LIT_W] = lit(1'b0, 7);
  endtask

  task automatic start_run(input logic [VAW-1:0] v, output int t0);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.var_i   = v;
    t0          = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.var_i   = VAW'($urandom_range(1, 2047));
  endtask

  // Starts at the current negedge and scans until relative cycle last_rel.
  task automatic observe(input int t0, input int last_rel, output int first_done,
                         output int pulses, output logic [CNT_W-1:0] cnt);
    first_done = -1;
    pulses     = 0;
    cnt        = '1;
    while ((cyc - t0) <= last_rel) begin
      if (bus.done_o === 1'b1) begin
        pulses++;
        if (first_done < 0) begin
          first_done = cyc - t0;
          cnt        = bus.break_count_o;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_tests++; if (bus.break_count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.break_count_o); end
    n_tests++; if (bus.ct_rd_addr_o !== 11'd0) begin n_fail++; $display("FAIL reset_ct_addr: got %0d want 0", bus.ct_rd_addr_o); end
    n_tests++; if (bus.var_rd_addr_o !== 11'd0) begin n_fail++; $display("FAIL reset_var_addr: got %0d want 0", bus.var_rd_addr_o); end
    n_tests++; if (bus.state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_break();
    int t0, fd, np;
    logic [CNT_W-1:0] cnt;
    set_single();
    start_run(11'd9, t0);
    n_tests++; if (bus.ct_rd_addr_o !== 11'd9) begin n_fail++; $display("FAIL single_ct_addr: got %0d want 9", bus.ct_rd_addr_o); end
    n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b want 1", bus.busy_o); end
    observe(t0, 45, fd, np, cnt);
    n_tests++; if (fd !== 44) begin n_fail++; $display("FAIL single_latency: got %0d want 44", fd); end
    n_tests++; if (np !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", np); end
    n_tests++; if (cnt !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", cnt); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", bus.busy_o); end
    n_tests++; if (bus.break_count_o !== 5'd1) begin n_fail++; $display("FAIL single_count_held: got %0d want 1", bus.break_count_o); end
  endtask

  task automatic test_negated();
    int t0, fd, np;
    logic [CNT_W-1:0] cnt;
    for (int c = 0; c < 2; c++) begin
      set_single();
      if (c == 0) tbl_word[0 +: LIT_W] = lit(1'b1, 5);
      else        var_mem[7] = 1'b1;
      start_run(11'd9, t0);
      observe(t0, 45, fd, np, cnt);
      n_tests++; if (fd !== 44) begin n_fail++; $display("FAIL negated_latency case %0d: got %0d want 44", c, fd); end
      n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL negated_count case %0d: got %0d want 0", c, cnt); end
    end
  endtask

  task automatic test_full_table();
    int t0, fd, np;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] want;
    for (int c = 0; c < 2; c++) begin
      clear_mem();
      tbl_addr = 11'd300;
      for (int s = 0; s < CC; s++) begin
        tbl_word[(2*s) * LIT_W +: LIT_W]   = lit(1'b0, 100 + 2*s);
        tbl_word[(2*s+1) * LIT_W +: LIT_W] = lit(1'b1, 101 + 2*s);
        var_mem[101 + 2*s] = 1'b1;
      end
      want = 5'd20;
      if (c == 1) begin
        var_mem[106] = 1'b1;
        var_mem[116] = 1'b1;
        var_mem[130] = 1'b1;
        want = 5'd17;
      end
      start_run(11'd300, t0);
      observe(t0, 45, fd, np, cnt);
      n_tests++; if (fd !== 44) begin n_fail++; $display("FAIL full_latency case %0d: got %0d want 44", c, fd); end
      n_tests++; if (cnt !== want) begin n_fail++; $display("FAIL full_count case %0d: got %0d want %0d", c, cnt, want); end
    end
  endtask

  task automatic test_back_to_back();
    int t0, rel, np, fd1, fd2;
    logic [CNT_W-1:0] cnt1, cnt2;
    set_single();
    start_run(11'd9, t0);
    np = 0; fd1 = -1; fd2 = -1; cnt1 = '1; cnt2 = '1;
    rel = cyc - t0;
    while (rel <= 95) begin
      if (bus.done_o === 1'b1) begin
        np++;
        if (fd1 < 0) begin fd1 = rel; cnt1 = bus.break_count_o; end
        else if (fd2 < 0) begin fd2 = rel; cnt2 = bus.break_count_o; end
      end
      if (rel == 12) begin
        n_tests++; if (bus.ct_rd_addr_o !== 11'd9) begin n_fail++; $display("FAIL guard_ct_addr: got %0d want 9", bus.ct_rd_addr_o); end
      end
      if (rel == 45) begin
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL guard_busy_t45: got %b want 0", bus.busy_o); end
      end
      if (rel == 46) begin
        n_tests++; if (bus.ct_rd_addr_o !== 11'd33) begin n_fail++; $display("FAIL guard_accept_addr: got %0d want 33", bus.ct_rd_addr_o); end
      end
      bus.start_i = (rel == 10) || (rel == 45);
      if (bus.start_i) bus.var_i = 11'd33;
      @(negedge clk);
      rel = cyc - t0;
    end
    bus.start_i = 1'b0;
    n_tests++; if (fd1 !== 44) begin n_fail++; $display("FAIL guard_first_done: got %0d want 44", fd1); end
    n_tests++; if (cnt1 !== 5'd1) begin n_fail++; $display("FAIL guard_first_count: got %0d want 1", cnt1); end
    n_tests++; if (fd2 !== 89) begin n_fail++; $display("FAIL guard_second_done: got %0d want 89", fd2); end
    n_tests++; if (cnt2 !== 5'd0) begin n_fail++; $display("FAIL guard_second_count: got %0d want 0", cnt2); end
    n_tests++; if (np !== 2) begin n_fail++; $display("FAIL guard_pulses: got %0d want 2", np); end
  endtask

  task automatic test_reset_mid_eval();
    int t0, fd, np, nd;
    logic [CNT_W-1:0] cnt;
    set_single();
    start_run(11'd9, t0);
    observe(t0, 19, fd, np, cnt);
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus.busy_o); end
    n_tests++; if (bus.ct_rd_addr_o !== 11'd0) begin n_fail++; $display("FAIL midrst_ct_addr: got %0d want 0", bus.ct_rd_addr_o); end
    n_tests++; if (bus.var_rd_addr_o !== 11'd0) begin n_fail++; $display("FAIL midrst_var_addr: got %0d want 0", bus.var_rd_addr_o); end
    n_tests++; if (bus.state_dbg !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", bus.state_dbg); end
    n_tests++; if (bus.break_count_o !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", bus.break_count_o); end
    nd = np;
    repeat (2) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) nd++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) nd++;
    end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", nd); end
    start_run(11'd9, t0);
    observe(t0, 45, fd, np, cnt);
    n_tests++; if (fd !== 44) begin n_fail++; $display("FAIL midrst_rerun_latency: got %0d want 44", fd); end
    n_tests++; if (cnt !== 5'd1) begin n_fail++; $display("FAIL midrst_rerun_count: got %0d want 1", cnt); end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.var_i   = '0;
    tbl_addr    = '0;
    clear_mem();
    test_reset();
    test_single_break();
    test_negated();
    test_full_table();
    test_back_to_back();
    test_reset_mid_eval();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
